// File: rtl/decode_dispatch_pkg.sv
// Shared constants for the decode/dispatch stage: RV32I opcodes,
// internal micro-op codes and dispatch targets.
package decode_dispatch_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd11;
    localparam logic [5:0] OP_LH    = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd13;
    localparam logic [5:0] OP_LBU   = 6'd14;
    localparam logic [5:0] OP_LHU   = 6'd15;
    localparam logic [5:0] OP_SB    = 6'd16;
    localparam logic [5:0] OP_SH    = 6'd17;
    localparam logic [5:0] OP_SW    = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SLTI  = 6'd20;
    localparam logic [5:0] OP_SLTIU = 6'd21;
    localparam logic [5:0] OP_XORI  = 6'd22;
    localparam logic [5:0] OP_ORI   = 6'd23;
    localparam logic [5:0] OP_ANDI  = 6'd24;
    localparam logic [5:0] OP_SLLI  = 6'd25;
    localparam logic [5:0] OP_SRLI  = 6'd26;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd28;
    localparam logic [5:0] OP_SUB   = 6'd29;
    localparam logic [5:0] OP_SLL   = 6'd30;
    localparam logic [5:0] OP_SLT   = 6'd31;
    localparam logic [5:0] OP_SLTU  = 6'd32;
    localparam logic [5:0] OP_XOR   = 6'd33;
    localparam logic [5:0] OP_SRL   = 6'd34;
    localparam logic [5:0] OP_SRA   = 6'd35;
    localparam logic [5:0] OP_OR    = 6'd36;
    localparam logic [5:0] OP_AND   = 6'd37;

    localparam int          ZERO_TAG_ROB = 0;
    localparam logic [4:0]  ZERO_TAG_REG = 5'd0;
    localparam logic [31:0] ZERO_DATA    = 32'd0;
    localparam logic        TRUE         = 1'b1;
    localparam logic        FALSE        = 1'b0;

    typedef enum logic [1:0] {
        TGT_ROB,
        TGT_RS,
        TGT_LSB
    } tgt_e;

endpackage

// File: rtl/decode_dispatch_operand_resolve.sv
// Resolves one source operand to value/tag from register file,
// CDB broadcast (lowest port wins) or ROB, in that priority.
module operand_resolve
    import decode_dispatch_pkg::*;
#(
    parameter int ROB_TAG_W = 4,
    parameter int CDB_PORTS = 2
) (
    input  logic                           rs_zero,
    input  logic                           busy,
    input  logic [31:0]                    reg_value,
    input  logic [ROB_TAG_W-1:0]           robtag,
    input  logic                           rob_ready,
    input  logic [31:0]                    rob_value,
    input  logic [CDB_PORTS-1:0]           cdb_valid,
    input  logic [CDB_PORTS*ROB_TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*32-1:0]        cdb_value,
    output logic [31:0]                    v,
    output logic [ROB_TAG_W-1:0]           q
);

    logic        hit;
    logic [31:0] hit_value;

    always_comb begin
        hit       = FALSE;
        hit_value = ZERO_DATA;
        // scan high to low so the lowest matching port overrides
        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cdb_valid[p] &&
                robtag != ROB_TAG_W'(ZERO_TAG_ROB) &&
                cdb_tag[p*ROB_TAG_W +: ROB_TAG_W] == robtag) begin
                hit       = TRUE;
                hit_value = cdb_value[p*32 +: 32];
            end
        end
    end

    always_comb begin
        v = ZERO_DATA;
        q = ROB_TAG_W'(ZERO_TAG_ROB);
        if (rs_zero) begin
            v = ZERO_DATA;
        end else if (!busy) begin
            v = reg_value;
        end else if (hit) begin
            v = hit_value;
        end else if (rob_ready) begin
            v = rob_value;
        end else begin
            q = robtag;
        end
    end

endmodule

// File: rtl/decode_dispatch.sv
// RV32I decode, rename/allocate and one-entry dispatch register
// that keeps snooping the CDB until the RS or LSB takes the micro-op.
module decode_dispatch
    import decode_dispatch_pkg::*;
#(
    parameter int ROB_TAG_W = 4,
    parameter int CDB_PORTS = 2,
    parameter int OP_W      = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           in_clr,
    input  logic                           in_fetch_valid,
    input  logic [31:0]                    in_fetch_instr,
    input  logic [31:0]                    in_fetch_pc,
    output logic                           out_fetch_ready,
    output logic [4:0]                     out_reg_tag1,
    output logic [4:0]                     out_reg_tag2,
    input  logic [31:0]                    in_reg_value1,
    input  logic [31:0]                    in_reg_value2,
    input  logic [ROB_TAG_W-1:0]           in_reg_robtag1,
    input  logic [ROB_TAG_W-1:0]           in_reg_robtag2,
    input  logic                           in_reg_busy1,
    input  logic                           in_reg_busy2,
    output logic [ROB_TAG_W-1:0]           out_rob_fetch_tag1,
    output logic [ROB_TAG_W-1:0]           out_rob_fetch_tag2,
    input  logic [31:0]                    in_rob_fetch_value1,
    input  logic [31:0]                    in_rob_fetch_value2,
    input  logic                           in_rob_fetch_ready1,
    input  logic                           in_rob_fetch_ready2,
    input  logic [ROB_TAG_W-1:0]           in_rob_freetag,
    input  logic                           in_rob_full,
    input  logic                           in_rs_full,
    input  logic                           in_lsb_full,
    input  logic [CDB_PORTS-1:0]           in_cdb_valid,
    input  logic [CDB_PORTS*ROB_TAG_W-1:0] in_cdb_tag,
    input  logic [CDB_PORTS*32-1:0]        in_cdb_value,
    output logic                           out_rob_alloc,
    output logic [OP_W-1:0]                out_rob_op,
    output logic [31:0]                    out_rob_destination,
    output logic                           out_rob_isready,
    output logic [31:0]                    out_rob_value,
    output logic [4:0]                     out_reg_destination,
    output logic [ROB_TAG_W-1:0]           out_reg_rob_tag,
    output logic [ROB_TAG_W-1:0]           out_rs_rob_tag,
    output logic [ROB_TAG_W-1:0]           out_lsb_rob_tag,
    output logic [OP_W-1:0]                out_op,
    output logic [31:0]                    out_value1,
    output logic [31:0]                    out_value2,
    output logic [ROB_TAG_W-1:0]           out_tag1,
    output logic [ROB_TAG_W-1:0]           out_tag2,
    output logic [31:0]                    out_imm,
    output logic [31:0]                    out_pc
);

    localparam int TW = ROB_TAG_W;

    logic            valid_q, valid_d;
    tgt_e            tgt_q, tgt_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [TW-1:0]   tag_q, tag_d, q1_q, q1_d, q2_q, q2_d;
    logic [31:0]     v1_q, v1_d, v2_q, v2_d;
    logic [31:0]     imm_q, imm_d, pc_q, pc_d;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    assign opcode = in_fetch_instr[6:0];
    assign rd     = in_fetch_instr[11:7];
    assign f3     = in_fetch_instr[14:12];
    assign f7     = in_fetch_instr[31:25];
    assign imm_i  = {{20{in_fetch_instr[31]}}, in_fetch_instr[31:20]};
    assign imm_s  = {{20{in_fetch_instr[31]}}, in_fetch_instr[31:25],
                     in_fetch_instr[11:7]};
    assign imm_b  = {{19{in_fetch_instr[31]}}, in_fetch_instr[31],
                     in_fetch_instr[7], in_fetch_instr[30:25],
                     in_fetch_instr[11:8], 1'b0};
    assign imm_u  = {in_fetch_instr[31:12], 12'd0};
    assign imm_j  = {{11{in_fetch_instr[31]}}, in_fetch_instr[31],
                     in_fetch_instr[19:12], in_fetch_instr[20],
                     in_fetch_instr[30:21], 1'b0};
    assign imm_sh = {26'd0, in_fetch_instr[25:20]};

    logic [5:0]  dop;
    tgt_e        dtgt;
    logic [31:0] dimm, dval;
    logic        dready, known;
    logic [4:0]  drd, rs1, rs2;

    always_comb begin
        dop    = OP_NOP;
        dtgt   = TGT_ROB;
        dimm   = ZERO_DATA;
        dval   = ZERO_DATA;
        dready = FALSE;
        drd    = ZERO_TAG_REG;
        rs1    = ZERO_TAG_REG;
        rs2    = ZERO_TAG_REG;
        known  = TRUE;
        unique case (opcode)
            OPC_LUI: begin
                dop = OP_LUI; dimm = imm_u; dval = imm_u;
                dready = TRUE; drd = rd;
            end
            OPC_AUIPC: begin
                dop = OP_AUIPC; dimm = imm_u; dval = in_fetch_pc + imm_u;
                dready = TRUE; drd = rd;
            end
            OPC_JAL: begin
                dop = OP_JAL; dimm = imm_j; dval = in_fetch_pc + 32'd4;
                dready = TRUE; drd = rd;
            end
            OPC_JALR: begin
                known = (f3 == 3'd0);
                dop = OP_JALR; dtgt = TGT_RS; dimm = imm_i;
                dval = in_fetch_pc + 32'd4; drd = rd;
                rs1 = in_fetch_instr[19:15];
            end
            OPC_BRANCH: begin
                dtgt = TGT_RS; dimm = imm_b;
                rs1 = in_fetch_instr[19:15]; rs2 = in_fetch_instr[24:20];
                case (f3)
                    3'd0: dop = OP_BEQ;
                    3'd1: dop = OP_BNE;
                    3'd4: dop = OP_BLT;
                    3'd5: dop = OP_BGE;
                    3'd6: dop = OP_BLTU;
                    3'd7: dop = OP_BGEU;
                    default: known = FALSE;
                endcase
            end
            OPC_LOAD: begin
                dtgt = TGT_LSB; dimm = imm_i; drd = rd;
                rs1 = in_fetch_instr[19:15];
                case (f3)
                    3'd0: dop = OP_LB;
                    3'd1: dop = OP_LH;
                    3'd2: dop = OP_LW;
                    3'd4: dop = OP_LBU;
                    3'd5: dop = OP_LHU;
                    default: known = FALSE;
                endcase
            end
            OPC_STORE: begin
                dtgt = TGT_LSB; dimm = imm_s;
                rs1 = in_fetch_instr[19:15]; rs2 = in_fetch_instr[24:20];
                case (f3)
                    3'd0: dop = OP_SB;
                    3'd1: dop = OP_SH;
                    3'd2: dop = OP_SW;
                    default: known = FALSE;
                endcase
            end
            OPC_OPIMM: begin
                dtgt = TGT_RS; dimm = imm_i; drd = rd;
                rs1 = in_fetch_instr[19:15];
                case (f3)
                    3'd0: dop = OP_ADDI;
                    3'd2: dop = OP_SLTI;
                    3'd3: dop = OP_SLTIU;
                    3'd4: dop = OP_XORI;
                    3'd6: dop = OP_ORI;
                    3'd7: dop = OP_ANDI;
                    3'd1: begin
                        dop = OP_SLLI; dimm = imm_sh; known = (f7 == 7'h00);
                    end
                    default: begin
                        dimm = imm_sh;
                        dop = (f7 == 7'h20) ? OP_SRAI : OP_SRLI;
                        known = (f7 == 7'h00) || (f7 == 7'h20);
                    end
                endcase
            end
            OPC_OP: begin
                dtgt = TGT_RS; drd = rd;
                rs1 = in_fetch_instr[19:15]; rs2 = in_fetch_instr[24:20];
                case ({f7, f3})
                    {7'h00, 3'd0}: dop = OP_ADD;
                    {7'h20, 3'd0}: dop = OP_SUB;
                    {7'h00, 3'd1}: dop = OP_SLL;
                    {7'h00, 3'd2}: dop = OP_SLT;
                    {7'h00, 3'd3}: dop = OP_SLTU;
                    {7'h00, 3'd4}: dop = OP_XOR;
                    {7'h00, 3'd5}: dop = OP_SRL;
                    {7'h20, 3'd5}: dop = OP_SRA;
                    {7'h00, 3'd6}: dop = OP_OR;
                    {7'h00, 3'd7}: dop = OP_AND;
                    default: known = FALSE;
                endcase
            end
            default: known = FALSE;
        endcase
        // anything unrecognised retires through the ROB as a ready NOP
        if (!known) begin
            dop = OP_NOP; dtgt = TGT_ROB; dimm = ZERO_DATA;
            dval = ZERO_DATA; dready = TRUE; drd = ZERO_TAG_REG;
            rs1 = ZERO_TAG_REG; rs2 = ZERO_TAG_REG;
        end
    end

    logic [31:0] a1_v, a2_v, h1_v, h2_v;
    logic [TW-1:0] a1_q, a2_q, h1_q, h2_q;

    operand_resolve #(.ROB_TAG_W(TW), .CDB_PORTS(CDB_PORTS)) u_acc1 (
        .rs_zero(rs1 == ZERO_TAG_REG), .busy(in_reg_busy1),
        .reg_value(in_reg_value1), .robtag(in_reg_robtag1),
        .rob_ready(in_rob_fetch_ready1), .rob_value(in_rob_fetch_value1),
        .cdb_valid(in_cdb_valid), .cdb_tag(in_cdb_tag),
        .cdb_value(in_cdb_value), .v(a1_v), .q(a1_q)
    );

    operand_resolve #(.ROB_TAG_W(TW), .CDB_PORTS(CDB_PORTS)) u_acc2 (
        .rs_zero(rs2 == ZERO_TAG_REG), .busy(in_reg_busy2),
        .reg_value(in_reg_value2), .robtag(in_reg_robtag2),
        .rob_ready(in_rob_fetch_ready2), .rob_value(in_rob_fetch_value2),
        .cdb_valid(in_cdb_valid), .cdb_tag(in_cdb_tag),
        .cdb_value(in_cdb_value), .v(a2_v), .q(a2_q)
    );

    // held operands: a nonzero tag acts as "busy" and waits for the CDB
    operand_resolve #(.ROB_TAG_W(TW), .CDB_PORTS(CDB_PORTS)) u_hold1 (
        .rs_zero(FALSE), .busy(q1_q != TW'(ZERO_TAG_ROB)),
        .reg_value(v1_q), .robtag(q1_q),
        .rob_ready(FALSE), .rob_value(ZERO_DATA),
        .cdb_valid(in_cdb_valid), .cdb_tag(in_cdb_tag),
        .cdb_value(in_cdb_value), .v(h1_v), .q(h1_q)
    );

    operand_resolve #(.ROB_TAG_W(TW), .CDB_PORTS(CDB_PORTS)) u_hold2 (
        .rs_zero(FALSE), .busy(q2_q != TW'(ZERO_TAG_ROB)),
        .reg_value(v2_q), .robtag(q2_q),
        .rob_ready(FALSE), .rob_value(ZERO_DATA),
        .cdb_valid(in_cdb_valid), .cdb_tag(in_cdb_tag),
        .cdb_value(in_cdb_value), .v(h2_v), .q(h2_q)
    );

    logic tgt_free, fire, accept, send;

    always_comb begin
        tgt_free = TRUE;
        if (tgt_q == TGT_RS)  tgt_free = !in_rs_full;
        if (tgt_q == TGT_LSB) tgt_free = !in_lsb_full;
    end

    assign fire            = rdy & valid_q & tgt_free;
    assign send            = fire & !in_clr;
    assign out_fetch_ready = rdy & !in_clr & !in_rob_full & (!valid_q | fire);
    assign accept          = in_fetch_valid & out_fetch_ready;

    always_comb begin
        valid_d = valid_q;
        tgt_d   = tgt_q;
        op_d    = op_q;
        tag_d   = tag_q;
        v1_d    = v1_q;
        q1_d    = q1_q;
        v2_d    = v2_q;
        q2_d    = q2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        if (rdy) begin
            if (in_clr) begin
                valid_d = FALSE;
            end else if (accept) begin
                valid_d = TRUE;
                tgt_d   = dtgt;
                op_d    = OP_W'(dop);
                tag_d   = in_rob_freetag;
                v1_d    = a1_v;
                q1_d    = a1_q;
                v2_d    = a2_v;
                q2_d    = a2_q;
                imm_d   = dimm;
                pc_d    = in_fetch_pc;
            end else if (fire) begin
                valid_d = FALSE;
            end else if (valid_q) begin
                v1_d = h1_v;
                q1_d = h1_q;
                v2_d = h2_v;
                q2_d = h2_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= FALSE;
            tgt_q   <= TGT_ROB;
            op_q    <= '0;
            tag_q   <= '0;
            v1_q    <= '0;
            q1_q    <= '0;
            v2_q    <= '0;
            q2_q    <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            tgt_q   <= tgt_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            v1_q    <= v1_d;
            q1_q    <= q1_d;
            v2_q    <= v2_d;
            q2_q    <= q2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
        end
    end

    assign out_reg_tag1        = rs1;
    assign out_reg_tag2        = rs2;
    assign out_rob_fetch_tag1  = in_reg_robtag1;
    assign out_rob_fetch_tag2  = in_reg_robtag2;
    assign out_rob_alloc       = accept;
    assign out_rob_op          = accept ? OP_W'(dop) : '0;
    assign out_rob_destination = accept ? {27'd0, drd} : ZERO_DATA;
    assign out_rob_isready     = accept & dready;
    assign out_rob_value       = accept ? dval : ZERO_DATA;
    assign out_reg_destination = accept ? drd : ZERO_TAG_REG;
    assign out_reg_rob_tag     = accept ? in_rob_freetag : '0;
    assign out_rs_rob_tag      = (send && tgt_q == TGT_RS) ? tag_q : '0;
    assign out_lsb_rob_tag     = (send && tgt_q == TGT_LSB) ? tag_q : '0;
    assign out_op              = op_q;
    assign out_value1          = h1_v;
    assign out_value2          = h2_v;
    assign out_tag1            = h1_q;
    assign out_tag2            = h2_q;
    assign out_imm             = imm_q;
    assign out_pc              = pc_q;

endmodule

// File: tb/tb_decode_dispatch.sv
// Directed bench for decode_dispatch: decode values, bypass, hold
// snoop, flush, async reset and global stall.
module tb_decode_dispatch;
    import decode_dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, in_clr, in_fetch_valid;
    logic [31:0] in_fetch_instr, in_fetch_pc;
    logic        out_fetch_ready;
    logic [4:0]  out_reg_tag1, out_reg_tag2;
    logic [31:0] in_reg_value1, in_reg_value2;
    logic [3:0]  in_reg_robtag1, in_reg_robtag2;
    logic        in_reg_busy1, in_reg_busy2;
    logic [3:0]  out_rob_fetch_tag1, out_rob_fetch_tag2;
    logic [31:0] in_rob_fetch_value1, in_rob_fetch_value2;
    logic        in_rob_fetch_ready1, in_rob_fetch_ready2;
    logic [3:0]  in_rob_freetag;
    logic        in_rob_full, in_rs_full, in_lsb_full;
    logic [1:0]  in_cdb_valid;
    logic [7:0]  in_cdb_tag;
    logic [63:0] in_cdb_value;
    logic        out_rob_alloc, out_rob_isready;
    logic [5:0]  out_rob_op, out_op;
    logic [31:0] out_rob_destination, out_rob_value;
    logic [4:0]  out_reg_destination;
    logic [3:0]  out_reg_rob_tag, out_rs_rob_tag, out_lsb_rob_tag;
    logic [31:0] out_value1, out_value2, out_imm, out_pc;
    logic [3:0]  out_tag1, out_tag2;

    int n_checks = 0;
    int n_fail = 0;

    decode_dispatch #(.ROB_TAG_W(4), .CDB_PORTS(2), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_clr(in_clr),
        .in_fetch_valid(in_fetch_valid), .in_fetch_instr(in_fetch_instr),
        .in_fetch_pc(in_fetch_pc), .out_fetch_ready(out_fetch_ready),
        .out_reg_tag1(out_reg_tag1), .out_reg_tag2(out_reg_tag2),
        .in_reg_value1(in_reg_value1), .in_reg_value2(in_reg_value2),
        .in_reg_robtag1(in_reg_robtag1), .in_reg_robtag2(in_reg_robtag2),
        .in_reg_busy1(in_reg_busy1), .in_reg_busy2(in_reg_busy2),
        .out_rob_fetch_tag1(out_rob_fetch_tag1),
        .out_rob_fetch_tag2(out_rob_fetch_tag2),
        .in_rob_fetch_value1(in_rob_fetch_value1),
        .in_rob_fetch_value2(in_rob_fetch_value2),
        .in_rob_fetch_ready1(in_rob_fetch_ready1),
        .in_rob_fetch_ready2(in_rob_fetch_ready2),
        .in_rob_freetag(in_rob_freetag), .in_rob_full(in_rob_full),
        .in_rs_full(in_rs_full), .in_lsb_full(in_lsb_full),
        .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag),
        .in_cdb_value(in_cdb_value), .out_rob_alloc(out_rob_alloc),
        .out_rob_op(out_rob_op), .out_rob_destination(out_rob_destination),
        .out_rob_isready(out_rob_isready), .out_rob_value(out_rob_value),
        .out_reg_destination(out_reg_destination),
        .out_reg_rob_tag(out_reg_rob_tag), .out_rs_rob_tag(out_rs_rob_tag),
        .out_lsb_rob_tag(out_lsb_rob_tag), .out_op(out_op),
        .out_value1(out_value1), .out_value2(out_value2),
        .out_tag1(out_tag1), .out_tag2(out_tag2),
        .out_imm(out_imm), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] I_LUI   = 32'h123452B7; // lui x5,0x12345
    localparam logic [31:0] I_ADDI  = 32'hFFF08193; // addi x3,x1,-1
    localparam logic [31:0] I_ADD   = 32'h00728333; // add x6,x5,x7
    localparam logic [31:0] I_JAL   = 32'h008000EF; // jal x1,+8
    localparam logic [31:0] I_BEQ   = 32'hFE208EE3; // beq x1,x2,-4
    localparam logic [31:0] I_LW    = 32'h00412403; // lw x8,4(x2)
    localparam logic [31:0] I_SRAI  = 32'h40325213; // srai x4,x4,3
    localparam logic [31:0] I_UNDEF = 32'hFFFFFFFF;

    task automatic idle();
        rdy = 1'b1; in_clr = 1'b0; in_fetch_valid = 1'b0;
        in_fetch_instr = 32'd0; in_fetch_pc = 32'd0;
        in_reg_value1 = 32'd0; in_reg_value2 = 32'd0;
        in_reg_robtag1 = 4'd0; in_reg_robtag2 = 4'd0;
        in_reg_busy1 = 1'b0; in_reg_busy2 = 1'b0;
        in_rob_fetch_value1 = 32'd0; in_rob_fetch_value2 = 32'd0;
        in_rob_fetch_ready1 = 1'b0; in_rob_fetch_ready2 = 1'b0;
        in_rob_freetag = 4'd0; in_rob_full = 1'b0;
        in_rs_full = 1'b0; in_lsb_full = 1'b0;
        in_cdb_valid = 2'b00; in_cdb_tag = 8'd0; in_cdb_value = 64'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        n_checks++; if (out_rs_rob_tag !== 4'd0) begin n_fail++; $display("FAIL reset_rs_tag: got %h exp 0", out_rs_rob_tag); end
        n_checks++; if (out_lsb_rob_tag !== 4'd0) begin n_fail++; $display("FAIL reset_lsb_tag: got %h exp 0", out_lsb_rob_tag); end
        n_checks++; if (out_rob_alloc !== 1'b0) begin n_fail++; $display("FAIL reset_alloc: got %b exp 0", out_rob_alloc); end
        n_checks++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h exp 0", out_pc); end
        n_checks++; if (out_reg_destination !== 5'd0) begin n_fail++; $display("FAIL reset_reg_dest: got %h exp 0", out_reg_destination); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_lui();
        idle();
        in_rob_freetag = 4'd3; in_fetch_valid = 1'b1;
        in_fetch_instr = I_LUI; in_fetch_pc = 32'h40;
        #1;
        n_checks++; if (out_rob_alloc !== 1'b1) begin n_fail++; $display("FAIL lui_alloc: got %b exp 1", out_rob_alloc); end
        n_checks++; if (out_rob_value !== 32'h12345000) begin n_fail++; $display("FAIL lui_value: got %h exp 12345000", out_rob_value); end
        n_checks++; if (out_rob_isready !== 1'b1) begin n_fail++; $display("FAIL lui_isready: got %b exp 1", out_rob_isready); end
        n_checks++; if (out_reg_destination !== 5'd5) begin n_fail++; $display("FAIL lui_reg_dest: got %0d exp 5", out_reg_destination); end
        n_checks++; if (out_reg_rob_tag !== 4'd3) begin n_fail++; $display("FAIL lui_rename_tag: got %0d exp 3", out_reg_rob_tag); end
        step();
        idle();
        #1;
        n_checks++; if (out_rs_rob_tag !== 4'd0) begin n_fail++; $display("FAIL lui_no_rs: got %0d exp 0", out_rs_rob_tag); end
        n_checks++; if (out_lsb_rob_tag !== 4'd0) begin n_fail++; $display("FAIL lui_no_lsb: got %0d exp 0", out_lsb_rob_tag); end
        step();
    endtask

    task automatic test_addi_bypass();
        idle();
        in_rob_freetag = 4'd5; in_fetch_valid = 1'b1; in_fetch_instr = I_ADDI;
        in_reg_busy1 = 1'b1; in_reg_robtag1 = 4'd2;
        in_cdb_valid = 2'b11; in_cdb_tag = {4'd2, 4'd6};
        in_cdb_value = {32'd7, 32'h55};
        #1;
        n_checks++; if (out_reg_tag1 !== 5'd1) begin n_fail++; $display("FAIL addi_rs1_idx: got %0d exp 1", out_reg_tag1); end
        n_checks++; if (out_rob_fetch_tag1 !== 4'd2) begin n_fail++; $display("FAIL addi_rob_query: got %0d exp 2", out_rob_fetch_tag1); end
        n_checks++; if (out_rob_isready !== 1'b0) begin n_fail++; $display("FAIL addi_isready: got %b exp 0", out_rob_isready); end
        step();
        idle();
        #1;
        n_checks++; if (out_rs_rob_tag !== 4'd5) begin n_fail++; $display("FAIL addi_rs_tag: got %0d exp 5", out_rs_rob_tag); end
        n_checks++; if (out_value1 !== 32'd7) begin n_fail++; $display("FAIL addi_v1: got %h exp 7", out_value1); end
        n_checks++; if (out_tag1 !== 4'd0) begin n_fail++; $display("FAIL addi_q1: got %0d exp 0", out_tag1); end
        n_checks++; if (out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm: got %h exp ffffffff", out_imm); end
        n_checks++; if (out_op !== OP_ADDI) begin n_fail++; $display("FAIL addi_op: got %0d exp %0d", out_op, OP_ADDI); end
        step();
    endtask

    task automatic test_hold_snoop();
        idle();
        in_rob_freetag = 4'd6; in_fetch_valid = 1'b1; in_fetch_instr = I_ADD;
        in_reg_value1 = 32'h11; in_reg_busy2 = 1'b1; in_reg_robtag2 = 4'd4;
        in_rs_full = 1'b1;
        #1;
        n_checks++; if (out_fetch_ready !== 1'b1) begin n_fail++; $display("FAIL hold_first_ready: got %b exp 1", out_fetch_ready); end
        step();
        in_fetch_instr = I_LUI; in_reg_busy2 = 1'b0;
        #1;
        n_checks++; if (out_fetch_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready_full: got %b exp 0", out_fetch_ready); end
        n_checks++; if (out_rs_rob_tag !== 4'd0) begin n_fail++; $display("FAIL hold_no_fire: got %0d exp 0", out_rs_rob_tag); end
        n_checks++; if (out_tag2 !== 4'd4) begin n_fail++; $display("FAIL hold_q2_wait: got %0d exp 4", out_tag2); end
        in_fetch_valid = 1'b0;
        in_cdb_valid = 2'b11; in_cdb_tag = {4'd4, 4'd4};
        in_cdb_value = {32'hBAD, 32'd9};
        #1;
        n_checks++; if (out_value2 !== 32'd9) begin n_fail++; $display("FAIL hold_bypass_v2: got %h exp 9", out_value2); end
        step();
        in_cdb_valid = 2'b00;
        #1;
        n_checks++; if (out_tag2 !== 4'd0) begin n_fail++; $display("FAIL hold_q2_cleared: got %0d exp 0", out_tag2); end
        n_checks++; if (out_value2 !== 32'd9) begin n_fail++; $display("FAIL hold_v2_kept: got %h exp 9", out_value2); end
        in_rs_full = 1'b0;
        #1;
        n_checks++; if (out_rs_rob_tag !== 4'd6) begin n_fail++; $display("FAIL hold_fire_tag: got %0d exp 6", out_rs_rob_tag); end
        n_checks++; if (out_value1 !== 32'h11) begin n_fail++; $display("FAIL hold_v1: got %h exp 11", out_value1); end
        n_checks++; if (out_op !== OP_ADD) begin n_fail++; $display("FAIL hold_op: got %0d exp %0d", out_op, OP_ADD); end
        step();
        n_checks++; if (out_rs_rob_tag !== 4'd0) begin n_fail++; $display("FAIL hold_after_fire: got %0d exp 0", out_rs_rob_tag); end
    endtask

    task automatic test_jal_beq();
        idle();
        in_rob_freetag = 4'd7; in_fetch_valid = 1'b1;
        in_fetch_instr = I_JAL; in_fetch_pc = 32'h100;
        #1;
        n_checks++; if (out_rob_value !== 32'h104) begin n_fail++; $display("FAIL jal_value: got %h exp 104", out_rob_value); end
        n_checks++; if (out_rob_isready !== 1'b1) begin n_fail++; $display("FAIL jal_isready: got %b exp 1", out_rob_isready); end
        n_checks++; if (out_reg_destination !== 5'd1) begin n_fail++; $display("FAIL jal_reg_dest: got %0d exp 1", out_reg_destination); end
        step();
        idle();
        #1;
        n_checks++; if (out_rs_rob_tag !== 4'd0) begin n_fail++; $display("FAIL jal_no_rs: got %0d exp 0", out_rs_rob_tag); end
        in_rob_freetag = 4'd8; in_fetch_valid = 1'b1;
        in_fetch_instr = I_BEQ; in_fetch_pc = 32'h200;
        in_reg_value1 = 32'd1; in_reg_value2 = 32'd2;
        #1;
        n_checks++; if (out_rob_destination !== 32'd0) begin n_fail++; $display("FAIL beq_rob_dest: got %h exp 0", out_rob_destination); end
        n_checks++; if (out_reg_destination !== 5'd0) begin n_fail++; $display("FAIL beq_reg_dest: got %0d exp 0", out_reg_destination); end
        n_checks++; if (out_reg_tag2 !== 5'd2) begin n_fail++; $display("FAIL beq_rs2_idx: got %0d exp 2", out_reg_tag2); end
        step();
        idle();
        #1;
        n_checks++; if (out_rs_rob_tag !== 4'd8) begin n_fail++; $display("FAIL beq_rs_tag: got %0d exp 8", out_rs_rob_tag); end
        n_checks++; if (out_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL beq_imm: got %h exp fffffffc", out_imm); end
        n_checks++; if (out_pc !== 32'h200) begin n_fail++; $display("FAIL beq_pc: got %h exp 200", out_pc); end
        n_checks++; if (out_op !== OP_BEQ) begin n_fail++; $display("FAIL beq_op: got %0d exp %0d", out_op, OP_BEQ); end
        n_checks++; if (out_value2 !== 32'd2) begin n_fail++; $display("FAIL beq_v2: got %h exp 2", out_value2); end
        step();
    endtask

    task automatic test_back_to_back();
        idle();
        in_rob_freetag = 4'd11; in_fetch_valid = 1'b1;
        in_fetch_instr = I_SRAI; in_reg_value1 = 32'h80;
        step();
        in_rob_freetag = 4'd12; in_fetch_instr = I_UNDEF;
        #1;
        n_checks++; if (out_rs_rob_tag !== 4'd11) begin n_fail++; $display("FAIL srai_rs_tag: got %0d exp 11", out_rs_rob_tag); end
        n_checks++; if (out_op !== OP_SRAI) begin n_fail++; $display("FAIL srai_op: got %0d exp %0d", out_op, OP_SRAI); end
        n_checks++; if (out_imm !== 32'd3) begin n_fail++; $display("FAIL srai_imm: got %h exp 3", out_imm); end
        n_checks++; if (out_fetch_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b exp 1", out_fetch_ready); end
        n_checks++; if (out_rob_op !== OP_NOP) begin n_fail++; $display("FAIL undef_op: got %0d exp %0d", out_rob_op, OP_NOP); end
        n_checks++; if (out_rob_isready !== 1'b1) begin n_fail++; $display("FAIL undef_isready: got %b exp 1", out_rob_isready); end
        n_checks++; if (out_rob_destination !== 32'd0) begin n_fail++; $display("FAIL undef_dest: got %h exp 0", out_rob_destination); end
        step();
        idle();
        #1;
        n_checks++; if (out_rs_rob_tag !== 4'd0) begin n_fail++; $display("FAIL undef_no_rs: got %0d exp 0", out_rs_rob_tag); end
        n_checks++; if (out_lsb_rob_tag !== 4'd0) begin n_fail++; $display("FAIL undef_no_lsb: got %0d exp 0", out_lsb_rob_tag); end
        step();
    endtask

    task automatic test_clr();
        idle();
        in_rob_freetag = 4'd9; in_fetch_valid = 1'b1; in_fetch_instr = I_LW;
        in_fetch_pc = 32'h300; in_reg_value1 = 32'h1000; in_lsb_full = 1'b1;
        step();
        in_fetch_valid = 1'b0;
        #1;
        n_checks++; if (out_lsb_rob_tag !== 4'd0) begin n_fail++; $display("FAIL lw_held_full: got %0d exp 0", out_lsb_rob_tag); end
        n_checks++; if (out_imm !== 32'd4) begin n_fail++; $display("FAIL lw_imm: got %h exp 4", out_imm); end
        n_checks++; if (out_value1 !== 32'h1000) begin n_fail++; $display("FAIL lw_v1: got %h exp 1000", out_value1); end
        in_clr = 1'b1; in_lsb_full = 1'b0;
        in_fetch_valid = 1'b1; in_fetch_instr = I_LUI;
        #1;
        n_checks++; if (out_lsb_rob_tag !== 4'd0) begin n_fail++; $display("FAIL clr_suppress: got %0d exp 0", out_lsb_rob_tag); end
        n_checks++; if (out_fetch_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %b exp 0", out_fetch_ready); end
        n_checks++; if (out_rob_alloc !== 1'b0) begin n_fail++; $display("FAIL clr_alloc: got %b exp 0", out_rob_alloc); end
        step();
        in_clr = 1'b0; in_fetch_valid = 1'b0;
        #1;
        n_checks++; if (out_lsb_rob_tag !== 4'd0) begin n_fail++; $display("FAIL clr_valid_gone: got %0d exp 0", out_lsb_rob_tag); end
        n_checks++; if (out_fetch_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready_after: got %b exp 1", out_fetch_ready); end
        step();
    endtask

    task automatic test_async_reset();
        idle();
        in_rob_freetag = 4'd10; in_fetch_valid = 1'b1; in_fetch_instr = I_LW;
        in_fetch_pc = 32'h300; in_reg_value1 = 32'h2000; in_lsb_full = 1'b1;
        step();
        idle();
        in_lsb_full = 1'b1;
        #1;
        n_checks++; if (out_pc !== 32'h300) begin n_fail++; $display("FAIL rst_pre_pc: got %h exp 300", out_pc); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL rst_async_pc: got %h exp 0", out_pc); end
        n_checks++; if (out_imm !== 32'd0) begin n_fail++; $display("FAIL rst_async_imm: got %h exp 0", out_imm); end
        n_checks++; if (out_value1 !== 32'd0) begin n_fail++; $display("FAIL rst_async_v1: got %h exp 0", out_value1); end
        in_lsb_full = 1'b0;
        #1;
        n_checks++; if (out_lsb_rob_tag !== 4'd0) begin n_fail++; $display("FAIL rst_async_lsb: got %0d exp 0", out_lsb_rob_tag); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_rdy_low();
        idle();
        in_rob_freetag = 4'd12; in_fetch_valid = 1'b1; in_fetch_instr = I_LW;
        in_fetch_pc = 32'h400; in_lsb_full = 1'b1;
        step();
        rdy = 1'b0; in_lsb_full = 1'b0; in_fetch_instr = I_LUI;
        in_rob_freetag = 4'd13; in_fetch_pc = 32'h500;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (out_fetch_ready !== 1'b0) begin n_fail++; $display("FAIL rdy_ready_%0d: got %b exp 0", i, out_fetch_ready); end
            n_checks++; if (out_lsb_rob_tag !== 4'd0) begin n_fail++; $display("FAIL rdy_lsb_%0d: got %0d exp 0", i, out_lsb_rob_tag); end
            n_checks++; if (out_rob_alloc !== 1'b0) begin n_fail++; $display("FAIL rdy_alloc_%0d: got %b exp 0", i, out_rob_alloc); end
            step();
        end
        n_checks++; if (out_pc !== 32'h400) begin n_fail++; $display("FAIL rdy_pc_held: got %h exp 400", out_pc); end
        n_checks++; if (out_imm !== 32'd4) begin n_fail++; $display("FAIL rdy_imm_held: got %h exp 4", out_imm); end
        rdy = 1'b1; in_fetch_valid = 1'b0;
        #1;
        n_checks++; if (out_lsb_rob_tag !== 4'd12) begin n_fail++; $display("FAIL rdy_resume_lsb: got %0d exp 12", out_lsb_rob_tag); end
        step();
    endtask

    initial begin
        test_reset();
        test_lui();
        test_addi_bypass();
        test_hold_snoop();
        test_jal_beq();
        test_back_to_back();
        test_clr();
        test_async_reset();
        test_rdy_low();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
